// File: rtl/if_stage_sramlike.sv
// rtl/if_stage_sramlike.sv - MIPS instruction-fetch stage on an SRAM-like req/addr_ok/data_ok port
// Single outstanding fetch; taken branches redirect fetch after the delay slot has been accepted.
module if_stage_sramlike #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok
);

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_HOLD} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] npc;
  logic [31:0] fs_pc;
  logic [31:0] inst_buf;
  logic [31:0] br_tgt;
  logic        br_pend;
  logic        br_ready;

  logic        br_taken;
  logic [31:0] br_target;
  logic        is_empty;
  logic        fs_leave;
  logic        handshake;
  logic        br_cap;
  logic        buf_load;
  logic [31:0] bus_inst;
  logic [31:0] bus_pc;

  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  always_comb begin
    state_next     = state;
    buf_load       = 1'b0;
    is_empty       = (state == S_EMPTY);
    fs_to_ds_valid = (state == S_HOLD) || ((state == S_WAIT) && inst_data_ok);
    fs_leave       = fs_to_ds_valid && ds_allowin;
    inst_req       = is_empty || fs_leave;
    handshake      = inst_req && inst_addr_ok;
    br_cap         = br_taken && ds_allowin;

    // A branch leaving decode while the delay slot is already in flight redirects immediately.
    if (br_ready)
      inst_addr = br_tgt;
    else if (br_cap && !is_empty)
      inst_addr = br_target;
    else
      inst_addr = npc;

    bus_inst     = (state == S_HOLD) ? inst_buf : inst_rdata;
    bus_pc       = is_empty ? inst_addr : fs_pc;
    fs_to_ds_bus = {bus_inst, bus_pc};

    case (state)
      S_EMPTY: begin
        if (handshake)
          state_next = S_WAIT;
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (ds_allowin) begin
            state_next = handshake ? S_WAIT : S_EMPTY;
          end else begin
            state_next = S_HOLD;
            buf_load   = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (ds_allowin)
          state_next = handshake ? S_WAIT : S_EMPTY;
      end
      default: state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_EMPTY;
      npc      <= RESET_PC;
      fs_pc    <= RESET_PC - 32'd4;
      inst_buf <= 32'd0;
      br_tgt   <= 32'd0;
      br_pend  <= 1'b0;
      br_ready <= 1'b0;
    end else begin
      state <= state_next;
      if (buf_load)
        inst_buf <= inst_rdata;
      if (handshake) begin
        fs_pc <= inst_addr;
        npc   <= inst_addr + 32'd4;
      end

      if (handshake) begin
        if (br_ready || (br_cap && !is_empty)) begin
          br_ready <= 1'b0;
        end else if (br_pend) begin
          br_pend  <= 1'b0;
          br_ready <= 1'b1;
        end else if (br_cap) begin
          br_ready <= 1'b1;
          br_tgt   <= br_target;
        end
      end else if (br_cap) begin
        // In EMPTY the delay slot has not been accepted yet, so the redirect waits for it.
        if (is_empty)
          br_pend <= 1'b1;
        else
          br_ready <= 1'b1;
        br_tgt <= br_target;
      end
    end
  end

endmodule

// File: tb/tb_if_stage_sramlike.sv
// tb/tb_if_stage_sramlike.sv - randomized bench for if_stage_sramlike against a program-order fetch model
// Models instruction memory, a decode stage that may take branches, and the expected fetch order.
module tb_if_stage_sramlike;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;

  if_stage_sramlike #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_bus(br_bus),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int unsigned aok_pct, allow_pct, br_pct, lat_max;
  logic        force_en;
  logic [31:0] force_pc, force_tgt;
  logic [31:0] block_addr;
  int          block_cnt;

  logic [31:0] exp_fetch;
  logic        rd_valid;
  logic [31:0] rd_slot, rd_tgt;
  logic [31:0] q_pc[$];
  logic        mem_out;
  int          mem_cnt;
  logic [31:0] mem_addr;
  logic        fs_has;
  logic        ds_valid, ds_branch, last_br;
  logic [31:0] ds_tgt;
  logic        prev_stall;
  logic [31:0] prev_addr;

  function automatic logic [31:0] f_inst(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h24010001;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    exp_fetch  = RESET_PC;
    rd_valid   = 1'b0;
    rd_slot    = '0;
    rd_tgt     = '0;
    q_pc.delete();
    mem_out    = 1'b0;
    mem_cnt    = 0;
    mem_addr   = '0;
    fs_has     = 1'b0;
    ds_valid   = 1'b0;
    ds_branch  = 1'b0;
    ds_tgt     = '0;
    last_br    = 1'b0;
    prev_stall = 1'b0;
    prev_addr  = '0;
    block_cnt  = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    ds_allowin = 1'b0; br_bus = '0; inst_rdata = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_req", 64'(inst_req), 64'd1);
    chk("rst_addr", 64'(inst_addr), 64'(RESET_PC));
    chk("rst_valid", 64'(fs_to_ds_valid), 64'd0);
    // stale data return while nothing is outstanding must be ignored
    inst_data_ok = 1'b1; inst_rdata = 32'hdeadbeef; ds_allowin = 1'b1;
    #1;
    chk("stale_valid", 64'(fs_to_ds_valid), 64'd0);
    chk("stale_addr", 64'(inst_addr), 64'(RESET_PC));
    prev_stall = 1'b1;
    prev_addr  = RESET_PC;
  endtask

  task automatic cycle();
    logic        data_now, exp_valid, exp_req, leave, hs, aok_v, brn;
    logic [31:0] pc, tgt;
    @(negedge clk);
    data_now   = mem_out && (mem_cnt == 0);
    ds_allowin = ($urandom_range(99) < allow_pct);
    exp_valid  = fs_has || data_now;
    exp_req    = (!fs_has && !mem_out) || (exp_valid && ds_allowin);
    aok_v      = ($urandom_range(99) < aok_pct);
    if (block_cnt > 0 && exp_req && exp_fetch == block_addr) begin
      aok_v = 1'b0;
      block_cnt--;
    end
    inst_addr_ok = aok_v;
    inst_data_ok = data_now;
    inst_rdata   = data_now ? f_inst(mem_addr) : $urandom;
    br_bus       = {ds_valid && ds_branch, ds_tgt};
    #1;

    chk("valid", 64'(fs_to_ds_valid), 64'(exp_valid));
    chk("req", 64'(inst_req), 64'(exp_req));
    if (exp_valid && q_pc.size() > 0) begin
      chk("bus_pc", 64'(fs_to_ds_bus[31:0]), 64'(q_pc[0]));
      chk("bus_inst", 64'(fs_to_ds_bus[63:32]), 64'(f_inst(q_pc[0])));
    end
    if (!fs_has && !mem_out)
      chk("empty_pc", 64'(fs_to_ds_bus[31:0]), 64'(inst_addr));
    if (prev_stall)
      chk("addr_stable", 64'(inst_addr), 64'(prev_addr));
    hs = inst_req && inst_addr_ok;
    if (hs)
      chk("fetch_addr", 64'(inst_addr), 64'(exp_fetch));

    leave = exp_valid && ds_allowin;
    if (ds_allowin) begin
      ds_valid  = leave;
      ds_branch = 1'b0;
      if (leave && q_pc.size() > 0) begin
        pc  = q_pc.pop_front();
        brn = !last_br && (force_en ? (pc == force_pc) : ($urandom_range(99) < br_pct));
        tgt = force_en ? force_tgt : ($urandom & 32'hfffffffc);
        ds_branch = brn;
        ds_tgt    = tgt;
        last_br   = brn;
        if (brn) begin
          rd_valid = 1'b1;
          rd_slot  = pc + 32'd4;
          rd_tgt   = tgt;
        end
      end
    end
    if (leave)
      fs_has = 1'b0;
    else if (data_now)
      fs_has = 1'b1;
    if (data_now)
      mem_out = 1'b0;
    else if (mem_out)
      mem_cnt--;
    if (hs) begin
      q_pc.push_back(inst_addr);
      mem_out  = 1'b1;
      mem_cnt  = int'($urandom_range(lat_max - 1));
      mem_addr = inst_addr;
      if (rd_valid && inst_addr == rd_slot) begin
        exp_fetch = rd_tgt;
        rd_valid  = 1'b0;
      end else begin
        exp_fetch = inst_addr + 32'd4;
      end
    end
    prev_stall = inst_req && !inst_addr_ok;
    prev_addr  = inst_addr;
  endtask

  initial begin
    reset = 1'b1; ds_allowin = 1'b0; br_bus = '0;
    inst_addr_ok = 1'b0; inst_rdata = '0; inst_data_ok = 1'b0;
    aok_pct = 100; allow_pct = 100; br_pct = 0; lat_max = 1;
    force_en = 1'b1; force_pc = 32'hbfc00010; force_tgt = 32'hbfc00100;
    block_addr = '0;
    model_reset();

    // sequential fetch, then branch at bfc00010 captured while its delay slot is in WAIT
    do_reset();
    repeat (14) cycle();

    // decode stalls: instruction held against changing rdata
    allow_pct = 0;
    repeat (4) cycle();
    allow_pct = 100;
    repeat (3) cycle();

    // address not accepted for 3 cycles
    aok_pct = 0;
    repeat (3) cycle();
    aok_pct = 100;
    repeat (4) cycle();

    // branch leaves decode before its delay slot is accepted
    do_reset();
    block_addr = 32'hbfc00014;
    block_cnt  = 3;
    repeat (16) cycle();

    // randomized traffic with random branches
    force_en = 1'b0;
    for (int blk = 0; blk < 60; blk++) begin
      aok_pct   = $urandom_range(100, 30);
      allow_pct = $urandom_range(100, 30);
      lat_max   = $urandom_range(3, 1);
      br_pct    = 25;
      repeat (50) cycle();
    end

    // reset with a fetch outstanding
    aok_pct = 100; allow_pct = 0; lat_max = 3;
    for (int i = 0; i < 20; i++) begin
      if (mem_out) break;
      cycle();
    end
    do_reset();
    allow_pct = 100; lat_max = 1;
    repeat (10) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
